// File: rtl/hwpe_stream_source_sequencer_if.sv
// Handshake bundles for the source sequencer: descriptor push port and
// the start/done control link towards hwpe_stream_source.
interface hwpe_seq_desc_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH = 16
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SIZE_WIDTH-1:0] size;

    modport master (output valid, output addr, output size, input ready);
    modport slave  (input valid, input addr, input size, output ready);
endinterface

interface hwpe_seq_src_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH = 16
);
    logic                  req_start;
    logic                  ready_start;
    logic                  done;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [SIZE_WIDTH-1:0] trans_size;

    modport master (output req_start, output base_addr, output trans_size,
                    input ready_start, input done);
    modport slave  (input req_start, input base_addr, input trans_size,
                    output ready_start, output done);
endinterface

// File: rtl/hwpe_stream_source_sequencer.sv
// Queues (address, size) descriptors and launches them one at a time on
// hwpe_stream_source, counting completed jobs.
module hwpe_stream_source_sequencer #(
    parameter int unsigned NB_DESC    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 8,
    localparam int unsigned PTR_W     = $clog2(NB_DESC),
    localparam int unsigned LVL_W     = $clog2(NB_DESC + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    hwpe_seq_desc_if.slave       desc,
    hwpe_seq_src_if.master       src,
    output logic                 job_done_o,
    output logic [CNT_WIDTH-1:0] job_cnt_o,
    output logic [LVL_W-1:0]     fifo_level_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_mem_addr [NB_DESC];
    logic [SIZE_WIDTH-1:0] r_mem_size [NB_DESC];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    logic [ADDR_WIDTH-1:0] r_base_addr;
    logic [SIZE_WIDTH-1:0] r_trans_size;
    logic                  r_job_done;
    logic [CNT_WIDTH-1:0]  r_job_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_job_done_next;
    logic                  w_fifo_full;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [SIZE_WIDTH-1:0] w_head_size;

    // Ready looks only at the level, so a full FIFO stays closed even in a pop cycle.
    assign w_fifo_full = (r_level == LVL_W'(NB_DESC));
    assign w_push      = desc.valid & ~w_fifo_full;
    assign w_head_addr = r_mem_addr[r_rd_ptr];
    assign w_head_size = r_mem_size[r_rd_ptr];

    // Storage is left unreset: the level and pointers define which entries are valid.
    generate
        for (genvar gi = 0; gi < NB_DESC; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem_addr[gi] <= desc.addr;
                    r_mem_size[gi] <= desc.size;
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        w_job_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_level != '0) && enable_i) begin
                    w_pop = 1'b1;
                    // Zero-length jobs retire immediately without bothering the source.
                    if (w_head_size != '0) begin
                        w_load       = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_job_done_next = 1'b1;
                    end
                end
            end
            S_START: begin
                if (src.ready_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (src.done) begin
                    w_state_next    = S_IDLE;
                    w_job_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_base_addr  <= '0;
            r_trans_size <= '0;
            r_job_done   <= 1'b0;
            r_job_cnt    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_job_done <= w_job_done_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_job_done_next) begin
                r_job_cnt <= r_job_cnt + 1'b1;
            end
            if (w_load) begin
                r_base_addr  <= w_head_addr;
                r_trans_size <= w_head_size;
            end
        end
    end

    assign desc.ready     = ~w_fifo_full;
    assign src.req_start  = (r_state == S_START);
    assign src.base_addr  = r_base_addr;
    assign src.trans_size = r_trans_size;
    assign job_done_o     = r_job_done;
    assign job_cnt_o      = r_job_cnt;
    assign fifo_level_o   = r_level;
    assign busy_o         = (r_state != S_IDLE) || (r_level != '0);

endmodule
